// File: rtl/db_pkg.sv
// Shared definitions for the data-buffer controller: state/mode encodings and
// the default buffer depth.
package db_pkg;

    localparam int DEPTH_DEF = 64;

    typedef logic [2:0] state_t;

    // Each state's code doubles as the externally visible mode value
    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_TX_FILL  = 3'd1;
    localparam state_t ST_TX_DRAIN = 3'd2;
    localparam state_t ST_RX_FILL  = 3'd3;
    localparam state_t ST_RX_DRAIN = 3'd4;
    localparam state_t ST_FLUSH    = 3'd5;

endpackage

// File: rtl/db_if.sv
// Buffer-side handshake bundle: access requests in, one-cycle buffer strobes out.
interface db_if;

    logic       ahb_wr_req;
    logic       ahb_rd_req;
    logic       usb_rx_wr_req;
    logic       usb_tx_rd_req;
    logic [6:0] buff_occ;
    logic       store_tx_data;
    logic       get_rx_data;
    logic       store_rx_data;
    logic       get_tx_data;
    logic       flush;

    modport master (
        input  ahb_wr_req, ahb_rd_req, usb_rx_wr_req, usb_tx_rd_req, buff_occ,
        output store_tx_data, get_rx_data, store_rx_data, get_tx_data, flush
    );

    modport slave (
        output ahb_wr_req, ahb_rd_req, usb_rx_wr_req, usb_tx_rd_req, buff_occ,
        input  store_tx_data, get_rx_data, store_rx_data, get_tx_data, flush
    );

endinterface

// File: rtl/db_pkt_counter.sv
// Byte counter for the current fill phase: synchronous clear, increment,
// saturating at DEPTH.
module db_pkt_counter
    import db_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       inc,
    output logic [6:0] cnt
);

    localparam logic [6:0] CNT_MAX = 7'(DEPTH);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (inc && (cnt < CNT_MAX))
            cnt <= cnt + 7'd1;
    end

endmodule

// File: rtl/db_ctrl.sv
// Data-buffer access controller: arbitrates host/USB requests into TX and RX
// fill/drain phases and issues zero-latency buffer strobes.
module db_ctrl
    import db_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic       clk,
    input  logic       n_rst,
    db_if.master       bus,
    input  logic       tx_start,
    input  logic       rx_packet_done,
    input  logic       tx_packet_done,
    input  logic       flush_req,
    output logic [2:0] mode,
    output logic [6:0] pkt_cnt,
    output logic       err,
    output logic       busy
);

    localparam logic [6:0] FULL_OCC = 7'(DEPTH);

    state_t state, state_nxt;
    logic   store_tx, get_rx, store_rx, get_tx;
    logic   illegal, cnt_clear;

    logic not_full, not_empty;
    assign not_full  = bus.buff_occ < FULL_OCC;
    assign not_empty = bus.buff_occ != '0;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        store_tx = 1'b0;
        get_tx   = 1'b0;
        store_rx = 1'b0;
        get_rx   = 1'b0;
        unique case (state)
            ST_TX_FILL:  store_tx = bus.ahb_wr_req    & not_full;
            ST_TX_DRAIN: get_tx   = bus.usb_tx_rd_req & not_empty;
            ST_RX_FILL:  store_rx = bus.usb_rx_wr_req & not_full;
            ST_RX_DRAIN: get_rx   = bus.ahb_rd_req    & not_empty;
            default: ;
        endcase
    end

    // A request is illegal when its state does not admit it, or when the
    // buffer refuses it because it is full or empty.
    always_comb begin
        illegal = 1'b0;
        case (state)
            ST_IDLE:     illegal = bus.ahb_rd_req | bus.usb_tx_rd_req;
            ST_TX_FILL:  illegal = bus.ahb_rd_req | bus.usb_rx_wr_req | bus.usb_tx_rd_req
                                 | (bus.ahb_wr_req & ~not_full);
            ST_TX_DRAIN: illegal = bus.ahb_wr_req | bus.ahb_rd_req | bus.usb_rx_wr_req
                                 | (bus.usb_tx_rd_req & ~not_empty);
            ST_RX_FILL:  illegal = bus.ahb_wr_req | bus.ahb_rd_req | bus.usb_tx_rd_req
                                 | (bus.usb_rx_wr_req & ~not_full);
            ST_RX_DRAIN: illegal = bus.ahb_wr_req | bus.usb_rx_wr_req | bus.usb_tx_rd_req
                                 | (bus.ahb_rd_req & ~not_empty);
            default:     illegal = bus.ahb_wr_req | bus.ahb_rd_req
                                 | bus.usb_rx_wr_req | bus.usb_tx_rd_req;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (flush_req) begin
            state_nxt = ST_FLUSH;
        end else begin
            case (state)
                ST_IDLE:
                    if (bus.usb_rx_wr_req)   state_nxt = ST_RX_FILL;
                    else if (bus.ahb_wr_req) state_nxt = ST_TX_FILL;
                ST_TX_FILL:
                    if (tx_start)            state_nxt = ST_TX_DRAIN;
                ST_TX_DRAIN:
                    if (tx_packet_done)      state_nxt = ST_IDLE;
                ST_RX_FILL:
                    if (rx_packet_done)
                        state_nxt = (not_empty || store_rx) ? ST_RX_DRAIN : ST_IDLE;
                ST_RX_DRAIN:
                    if (!not_empty && !get_rx) state_nxt = ST_IDLE;
                default:                     state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= illegal;
        end
    end

    assign cnt_clear = (state_nxt == ST_FLUSH)
                     | ((state_nxt == ST_TX_FILL) && (state != ST_TX_FILL))
                     | ((state_nxt == ST_RX_FILL) && (state != ST_RX_FILL));

    db_pkt_counter #(.DEPTH(DEPTH)) u_pkt_counter (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (cnt_clear),
        .inc   (store_tx | store_rx),
        .cnt   (pkt_cnt)
    );

    assign bus.store_tx_data = store_tx;
    assign bus.get_tx_data   = get_tx;
    assign bus.store_rx_data = store_rx;
    assign bus.get_rx_data   = get_rx;
    assign bus.flush         = (state == ST_FLUSH);
    assign mode              = state;
    assign busy              = (state != ST_IDLE);

endmodule

// File: tb/tb_db_ctrl.sv
// Directed bench for db_ctrl: reset, TX/RX paths, full/empty refusal,
// contention and flush, with hand-computed expectations.
module tb_db_ctrl;

    logic       clk;
    logic       n_rst;
    logic       tx_start, rx_packet_done, tx_packet_done, flush_req;
    logic [2:0] mode;
    logic [6:0] pkt_cnt;
    logic       err, busy;

    int n_chk = 0;
    int n_err = 0;
    int n_store = 0;
    int n_get = 0;

    db_if bus ();

    db_ctrl #(.DEPTH(64)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .bus            (bus),
        .tx_start       (tx_start),
        .rx_packet_done (rx_packet_done),
        .tx_packet_done (tx_packet_done),
        .flush_req      (flush_req),
        .mode           (mode),
        .pkt_cnt        (pkt_cnt),
        .err            (err),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.ahb_wr_req    = 1'b0;
        bus.ahb_rd_req    = 1'b0;
        bus.usb_rx_wr_req = 1'b0;
        bus.usb_tx_rd_req = 1'b0;
        bus.buff_occ      = 7'd0;
        tx_start       = 1'b0;
        rx_packet_done = 1'b0;
        tx_packet_done = 1'b0;
        flush_req      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] strobes();
        return {bus.store_tx_data, bus.get_tx_data, bus.store_rx_data, bus.get_rx_data};
    endfunction

    initial begin
        idle_inputs();
        n_rst = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_mode", mode, 0);
        check("rst_pkt", pkt_cnt, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_flush", bus.flush, 0);
        check("rst_strobes", strobes(), 0);
        n_rst = 1'b1;
        tick();

        // TX path: enter, 4 stores, start, 4 fetches (occ 4..1), done
        bus.ahb_wr_req = 1'b1;
        #1 check("tx_idle_nostore", bus.store_tx_data, 0);
        tick();
        check("tx_fill_mode", mode, 1);
        check("tx_fill_pkt0", pkt_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            bus.buff_occ = 7'(i);
            #1;
            check("tx_store", bus.store_tx_data, 1);
            n_store += int'(bus.store_tx_data);
            tick();
            check("tx_pkt", pkt_cnt, 32'(i + 1));
        end
        bus.ahb_wr_req = 1'b0;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        check("tx_drain_mode", mode, 2);
        for (int occ = 4; occ >= 1; occ--) begin
            bus.usb_tx_rd_req = 1'b1;
            bus.buff_occ = 7'(occ);
            #1;
            check("tx_get", bus.get_tx_data, 1);
            n_get += int'(bus.get_tx_data);
            tick();
            check("tx_get_err", err, 0);
        end
        bus.usb_tx_rd_req = 1'b0;
        bus.buff_occ = 7'd0;
        tx_packet_done = 1'b1;
        tick();
        tx_packet_done = 1'b0;
        check("tx_n_store", n_store, 4);
        check("tx_n_get", n_get, 4);
        check("tx_done_mode", mode, 0);
        check("tx_done_pkt", pkt_cnt, 4);
        check("tx_done_busy", busy, 0);

        // Asynchronous reset in the middle of TX_FILL
        bus.ahb_wr_req = 1'b1;
        tick();
        tick();
        check("mid_pkt1", pkt_cnt, 1);
        check("mid_store_hi", bus.store_tx_data, 1);
        #2 n_rst = 1'b0;
        #1;
        check("mid_rst_mode", mode, 0);
        check("mid_rst_pkt", pkt_cnt, 0);
        check("mid_rst_strobes", strobes(), 0);
        check("mid_rst_flush", bus.flush, 0);
        #1 n_rst = 1'b1;
        bus.ahb_wr_req = 1'b0;
        tick();
        check("mid_rst_idle", mode, 0);

        // Contention in IDLE favours RX_FILL
        bus.ahb_wr_req = 1'b1;
        bus.usb_rx_wr_req = 1'b1;
        tick();
        bus.ahb_wr_req = 1'b0;
        check("cont_mode", mode, 3);
        check("cont_err", err, 0);

        // One RX store, then refusal at full
        bus.buff_occ = 7'd5;
        #1 check("rx_store", bus.store_rx_data, 1);
        tick();
        check("rx_pkt1", pkt_cnt, 1);
        bus.buff_occ = 7'd64;
        #1 check("full_nostore", bus.store_rx_data, 0);
        tick();
        check("full_err", err, 1);
        check("full_pkt", pkt_cnt, 1);
        bus.usb_rx_wr_req = 1'b0;
        tick();
        check("full_err_once", err, 0);

        // Packet done with data -> RX_DRAIN, drain one, then flush
        bus.buff_occ = 7'd10;
        rx_packet_done = 1'b1;
        tick();
        rx_packet_done = 1'b0;
        check("rx_drain_mode", mode, 4);
        bus.ahb_rd_req = 1'b1;
        #1 check("rx_get", bus.get_rx_data, 1);
        tick();
        check("rx_drain_stay", mode, 4);
        bus.ahb_rd_req = 1'b0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check("flush_mode", mode, 5);
        check("flush_strobe", bus.flush, 1);
        check("flush_pkt", pkt_cnt, 0);
        check("flush_nodata", strobes(), 0);
        tick();
        check("flush_exit", mode, 0);
        check("flush_off", bus.flush, 0);
        check("flush_pkt_idle", pkt_cnt, 0);

        // Empty packet: RX_FILL with occ 0 -> IDLE, no get_rx_data
        bus.buff_occ = 7'd0;
        bus.usb_rx_wr_req = 1'b1;
        tick();
        bus.usb_rx_wr_req = 1'b0;
        rx_packet_done = 1'b1;
        #1 check("empty_noget", bus.get_rx_data, 0);
        tick();
        rx_packet_done = 1'b0;
        check("empty_mode", mode, 0);
        check("empty_noget2", bus.get_rx_data, 0);

        // Done coincides with a store at occ 0 -> RX_DRAIN, drain to empty
        bus.usb_rx_wr_req = 1'b1;
        tick();
        rx_packet_done = 1'b1;
        tick();
        bus.usb_rx_wr_req = 1'b0;
        rx_packet_done = 1'b0;
        check("grant_drain_mode", mode, 4);
        check("grant_pkt", pkt_cnt, 1);
        bus.buff_occ = 7'd1;
        bus.ahb_rd_req = 1'b1;
        tick();
        bus.ahb_rd_req = 1'b0;
        bus.buff_occ = 7'd0;
        check("drain_last_mode", mode, 4);
        tick();
        check("drain_empty_idle", mode, 0);

        // Illegal request in IDLE gives a single err pulse
        bus.usb_tx_rd_req = 1'b1;
        tick();
        bus.usb_tx_rd_req = 1'b0;
        check("illegal_err", err, 1);
        check("illegal_stay", mode, 0);
        tick();
        check("illegal_err_clr", err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
